// File: rtl/nanorv32_inst_align.sv
// Instruction aligner: splits 32-bit fetch words into 16/32-bit RISC-V instructions,
// carrying an odd halfword across word boundaries in a hold register.
module nanorv32_inst_align #(
  parameter logic [31:0] IDLE_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        flush_pc1,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic        inst_compressed,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    SKIP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_q, hold_d;

  logic        lo_c, hold_c;
  logic        vld, comp;
  logic [31:0] raw;
  logic        word_xfer, inst_xfer;

  assign lo_c   = (word_data[1:0] != 2'b11);
  assign hold_c = (hold_q[1:0] != 2'b11);

  always_comb begin
    vld        = 1'b0;
    comp       = 1'b0;
    raw        = '0;
    word_ready = 1'b0;
    state_d    = state_q;
    hold_d     = hold_q;

    // word_ready is a function of state, inst_ready and flush only, never word_data
    case (state_q)
      EMPTY: begin
        vld        = word_valid;
        word_ready = inst_ready;
        comp       = lo_c;
        raw        = lo_c ? {16'h0000, word_data[15:0]} : word_data;
      end
      HALF: begin
        if (hold_c) begin
          vld  = 1'b1;
          comp = 1'b1;
          raw  = {16'h0000, hold_q};
        end else begin
          vld        = word_valid;
          word_ready = inst_ready;
          raw        = {word_data[15:0], hold_q};
        end
      end
      SKIP: begin
        word_ready = 1'b1;
      end
      default: begin
        word_ready = 1'b0;
      end
    endcase

    if (flush) begin
      vld        = 1'b0;
      word_ready = 1'b0;
    end

    word_xfer = word_valid & word_ready;
    inst_xfer = vld & inst_ready;

    if (flush) begin
      state_d = flush_pc1 ? SKIP : EMPTY;
      hold_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inst_xfer && lo_c) begin
            hold_d  = word_data[31:16];
            state_d = HALF;
          end
        end
        HALF: begin
          if (hold_c) begin
            if (inst_xfer) state_d = EMPTY;
          end else if (word_xfer) begin
            hold_d = word_data[31:16];
          end
        end
        SKIP: begin
          if (word_xfer) begin
            hold_d  = word_data[31:16];
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign inst_valid      = vld;
  assign inst_data       = vld ? raw : IDLE_INST;
  assign inst_compressed = vld & comp;

endmodule
